// File: rtl/pokey_pkg.sv
// Shared definitions for the POKEY keyboard scan logic.
// Contents: scan FSM state type, scan index width, default modifier/break
// scan indices, SKCTL bit positions, and a KBCODE packing helper.
package pokey_pkg;

  localparam int unsigned SCAN_W = 6;

  typedef enum logic [1:0] {
    StIdle,
    StConfirm,
    StHeld
  } scan_state_e;

  localparam logic [SCAN_W-1:0] SHIFT_IDX_DEF = 6'h3E;
  localparam logic [SCAN_W-1:0] CTRL_IDX_DEF  = 6'h3F;
  localparam logic [SCAN_W-1:0] BREAK_IDX_DEF = 6'h30;

  // SKCTL bit positions feeding kb_enable / debounce_en
  localparam int unsigned SKCTL_KB_ENABLE_BIT = 1;
  localparam int unsigned SKCTL_DEBOUNCE_BIT  = 0;

  function automatic logic [7:0] make_kbcode(input logic ctrl, input logic shift,
                                             input logic [SCAN_W-1:0] idx);
    return {ctrl, shift, idx};
  endfunction

endpackage

// File: rtl/pokey_key_scan_ctrl_if.sv
// Bus bundle between the keyboard scan controller and its surroundings.
// Signals prefixed i_ are inputs to the controller, o_ are its outputs.
//   i_kb_enable, i_debounce_en : SKCTL controls
//   i_scan_tick                : one-cycle pulse advancing the scan by one key
//   i_kr1_L, i_kr2_L           : active-low key-matrix returns
//   i_irq_ack, i_ovr_clr       : one-cycle clears of key_irq / kb_overrun
//   o_key_scan_L               : inverted scan index driven to the matrix
//   o_kbcode                   : {ctrl, shift, index}
//   o_key_irq, o_break_irq     : keyboard IRQ (level), break IRQ (pulse)
//   o_key_down, o_shift_down   : live key / shift status
//   o_kb_overrun               : overrun flag
// Modports: slave = controller, master = driver of the controls.
interface pokey_key_scan_ctrl_if
  import pokey_pkg::*;
();

  logic              i_kb_enable;
  logic              i_debounce_en;
  logic              i_scan_tick;
  logic              i_kr1_L;
  logic              i_kr2_L;
  logic              i_irq_ack;
  logic              i_ovr_clr;
  logic [SCAN_W-1:0] o_key_scan_L;
  logic [7:0]        o_kbcode;
  logic              o_key_irq;
  logic              o_break_irq;
  logic              o_key_down;
  logic              o_shift_down;
  logic              o_kb_overrun;

  modport slave (
    input  i_kb_enable, i_debounce_en, i_scan_tick, i_kr1_L, i_kr2_L, i_irq_ack, i_ovr_clr,
    output o_key_scan_L, o_kbcode, o_key_irq, o_break_irq, o_key_down, o_shift_down,
           o_kb_overrun
  );

  modport master (
    output i_kb_enable, i_debounce_en, i_scan_tick, i_kr1_L, i_kr2_L, i_irq_ack, i_ovr_clr,
    input  o_key_scan_L, o_kbcode, o_key_irq, o_break_irq, o_key_down, o_shift_down,
           o_kb_overrun
  );

endinterface

// File: rtl/pokey_scan_counter.sv
// 6-bit keyboard scan index counter with registered inverted matrix address.
// Ports:
//   o2           : clock, rising edge
//   rst          : asynchronous active-high reset
//   i_en         : scanning enabled; low forces the index to 0
//   i_tick       : advance by one key (wraps 63 -> 0)
//   o_count      : current scan index
//   o_key_scan_L : registered ~index, updated together with the index
module pokey_scan_counter
  import pokey_pkg::*;
(
  input  logic              o2,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_tick,
  output logic [SCAN_W-1:0] o_count,
  output logic [SCAN_W-1:0] o_key_scan_L
);

  logic [SCAN_W-1:0] r_count;
  logic [SCAN_W-1:0] r_key_scan_L;
  logic [SCAN_W-1:0] w_count_inc;

  assign w_count_inc = r_count + 6'd1;

  always_ff @(posedge o2 or posedge rst) begin
    if (rst) begin
      r_count      <= '0;
      r_key_scan_L <= '1;
    end else if (!i_en) begin
      r_count      <= '0;
      r_key_scan_L <= '1;
    end else if (i_tick) begin
      r_count      <= w_count_inc;
      r_key_scan_L <= ~w_count_inc;
    end
  end

  assign o_count      = r_count;
  assign o_key_scan_L = r_key_scan_L;

endmodule

// File: rtl/pokey_key_scan_ctrl.sv
// POKEY keyboard scan sequencer: walks the 64-key matrix, runs the
// compare-latch debounce FSM, latches KBCODE with shift/control modifiers,
// and raises keyboard and break interrupt requests.
// Ports:
//   o2  : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : pokey_key_scan_ctrl_if.slave (controls, matrix returns, status)
// Optional feature macro: POKEY_KEY_OVERRUN_EN -- when defined, a latch while
// key_irq is still pending sets kb_overrun (cleared by ovr_clr, set wins);
// when undefined kb_overrun is tied low and ovr_clr is ignored.
module pokey_key_scan_ctrl
  import pokey_pkg::*;
#(
  parameter logic [SCAN_W-1:0] SHIFT_IDX = SHIFT_IDX_DEF,
  parameter logic [SCAN_W-1:0] CTRL_IDX  = CTRL_IDX_DEF,
  parameter logic [SCAN_W-1:0] BREAK_IDX = BREAK_IDX_DEF
) (
  input  logic                  o2,
  input  logic                  rst,
  pokey_key_scan_ctrl_if.slave  bus
);

  logic [SCAN_W-1:0] w_count;
  logic [SCAN_W-1:0] w_key_scan_L;
  logic              w_step;
  logic              w_key_hit;
  logic              w_kr2;
  logic              w_at_latch;

  scan_state_e       r_state;
  scan_state_e       w_state_d;

  logic              w_capture;
  logic              w_latch;
  logic [SCAN_W-1:0] w_latch_idx;

  logic [SCAN_W-1:0] r_comp_latch;
  logic              r_shift_st;
  logic              r_ctrl_st;
  logic              r_brk_prev;
  logic              r_break_irq;
  logic [7:0]        r_kbcode;
  logic              r_key_irq;
  logic              r_key_down;
  logic              r_kb_overrun;

  assign w_step     = bus.i_kb_enable & bus.i_scan_tick;
  assign w_key_hit  = ~bus.i_kr1_L;
  assign w_kr2      = ~bus.i_kr2_L;
  assign w_at_latch = (w_count == r_comp_latch);

  pokey_scan_counter u_scan_counter (
    .o2           (o2),
    .rst          (rst),
    .i_en         (bus.i_kb_enable),
    .i_tick       (bus.i_scan_tick),
    .o_count      (w_count),
    .o_key_scan_L (w_key_scan_L)
  );

  // FSM state register
  always_ff @(posedge o2 or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next state
  always_comb begin
    w_state_d = r_state;
    if (!bus.i_kb_enable) begin
      w_state_d = StIdle;
    end else if (w_step) begin
      unique case (r_state)
        StIdle: begin
          if (w_key_hit) w_state_d = bus.i_debounce_en ? StConfirm : StHeld;
        end
        StConfirm: begin
          // Only the remembered key matters; a miss there is a bounce.
          if (w_at_latch) w_state_d = w_key_hit ? StHeld : StIdle;
        end
        StHeld: begin
          if (w_at_latch && !w_key_hit) w_state_d = StIdle;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // FSM outputs: capture of the candidate index and the KBCODE latch strobe
  always_comb begin
    w_capture   = 1'b0;
    w_latch     = 1'b0;
    w_latch_idx = r_comp_latch;
    if (w_step) begin
      unique case (r_state)
        StIdle: begin
          if (w_key_hit) begin
            w_capture = 1'b1;
            if (!bus.i_debounce_en) begin
              // comp_latch is loaded this same edge, so take the live index
              w_latch     = 1'b1;
              w_latch_idx = w_count;
            end
          end
        end
        StConfirm: begin
          if (w_at_latch && w_key_hit) w_latch = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Modifier, break and key status registers
  always_ff @(posedge o2 or posedge rst) begin
    if (rst) begin
      r_comp_latch <= '0;
      r_shift_st   <= 1'b0;
      r_ctrl_st    <= 1'b0;
      r_brk_prev   <= 1'b0;
      r_break_irq  <= 1'b0;
      r_kbcode     <= 8'h00;
      r_key_irq    <= 1'b0;
      r_key_down   <= 1'b0;
    end else begin
      r_break_irq <= 1'b0;
      if (w_capture) r_comp_latch <= w_count;

      if (!bus.i_kb_enable) begin
        r_shift_st <= 1'b0;
      end else if (w_step) begin
        if (w_count == SHIFT_IDX) r_shift_st <= w_kr2;
        if (w_count == CTRL_IDX)  r_ctrl_st  <= w_kr2;
        if (w_count == BREAK_IDX) begin
          r_brk_prev  <= w_kr2;
          r_break_irq <= w_kr2 & ~r_brk_prev;
        end
      end

      r_key_down <= (w_state_d == StHeld);

      // Modifiers are the values from the most recent scan, not this tick.
      if (w_latch) r_kbcode <= make_kbcode(r_ctrl_st, r_shift_st, w_latch_idx);

      if (w_latch) begin
        r_key_irq <= 1'b1;
      end else if (bus.i_irq_ack) begin
        r_key_irq <= 1'b0;
      end
    end
  end

`ifdef POKEY_KEY_OVERRUN_EN
  always_ff @(posedge o2 or posedge rst) begin
    if (rst) begin
      r_kb_overrun <= 1'b0;
    end else if (w_latch && r_key_irq) begin
      r_kb_overrun <= 1'b1;
    end else if (bus.i_ovr_clr) begin
      r_kb_overrun <= 1'b0;
    end
  end
`else
  logic w_unused_ovr_clr;
  assign w_unused_ovr_clr = bus.i_ovr_clr;
  assign r_kb_overrun     = 1'b0;
`endif

  assign bus.o_key_scan_L = w_key_scan_L;
  assign bus.o_kbcode     = r_kbcode;
  assign bus.o_key_irq    = r_key_irq;
  assign bus.o_break_irq  = r_break_irq;
  assign bus.o_key_down   = r_key_down;
  assign bus.o_shift_down = r_shift_st;
  assign bus.o_kb_overrun = r_kb_overrun;

endmodule

// File: tb/tb_pokey_key_scan_ctrl.sv
// Directed self-checking bench for pokey_key_scan_ctrl. The bench keeps its
// own scan index and presents key-matrix returns for the simulated keyboard.
module tb_pokey_key_scan_ctrl;

`ifdef POKEY_KEY_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  logic o2 = 1'b0;
  logic rst = 1'b1;
  always #5 o2 = ~o2;

  pokey_key_scan_ctrl_if bus ();

  pokey_key_scan_ctrl dut (
    .o2  (o2),
    .rst (rst),
    .bus (bus)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int idx = 0;
  int key_idx = -1;
  bit shift_on = 0;
  bit ctrl_on = 0;
  bit brk_on = 0;
  int brk_pulses = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_ticks(input int n);
    logic [5:0] ix;
    logic [5:0] exp_l;
    for (int i = 0; i < n; i++) begin
      ix = idx[5:0];
      bus.i_scan_tick = 1'b1;
      bus.i_kr1_L = !(idx == key_idx);
      bus.i_kr2_L = !((shift_on && ix == 6'h3E) || (ctrl_on && ix == 6'h3F) ||
                      (brk_on && ix == 6'h30));
      @(posedge o2);
      #1;
      idx = (idx + 1) % 64;
      if (bus.o_break_irq === 1'b1) brk_pulses++;
      exp_l = ~idx[5:0];
      chk("key_scan_L", {2'b00, bus.o_key_scan_L}, {2'b00, exp_l});
    end
    bus.i_scan_tick = 1'b0;
    bus.i_kr1_L = 1'b1;
    bus.i_kr2_L = 1'b1;
  endtask

  task automatic run_to(input int t);
    while (idx != t) run_ticks(1);
  endtask

  initial begin
    bus.i_kb_enable   = 1'b0;
    bus.i_debounce_en = 1'b1;
    bus.i_scan_tick   = 1'b0;
    bus.i_kr1_L       = 1'b1;
    bus.i_kr2_L       = 1'b1;
    bus.i_irq_ack     = 1'b0;
    bus.i_ovr_clr     = 1'b0;
    repeat (2) @(posedge o2);
    #1;
    chk("rst key_scan_L", {2'b00, bus.o_key_scan_L}, 8'h3F);
    chk("rst kbcode", bus.o_kbcode, 8'h00);
    chk("rst key_irq", {7'd0, bus.o_key_irq}, 8'h00);
    chk("rst break_irq", {7'd0, bus.o_break_irq}, 8'h00);
    chk("rst key_down", {7'd0, bus.o_key_down}, 8'h00);
    chk("rst shift_down", {7'd0, bus.o_shift_down}, 8'h00);
    chk("rst kb_overrun", {7'd0, bus.o_kb_overrun}, 8'h00);

    @(negedge o2);
    rst = 1'b0;
    bus.i_kb_enable = 1'b1;
    idx = 0;

    // Debounced key at 0x15 over two scans
    key_idx = 'h15;
    run_to('h15);
    run_ticks(1);
    chk("t1 confirm key_irq", {7'd0, bus.o_key_irq}, 8'h00);
    chk("t1 confirm key_down", {7'd0, bus.o_key_down}, 8'h00);
    run_to('h15);
    chk("t1 pre key_irq", {7'd0, bus.o_key_irq}, 8'h00);
    run_ticks(1);
    chk("t1 kbcode", bus.o_kbcode, 8'h15);
    chk("t1 key_irq", {7'd0, bus.o_key_irq}, 8'h01);
    chk("t1 key_down", {7'd0, bus.o_key_down}, 8'h01);

    // Ack while held, then release
    run_ticks(3);
    bus.i_irq_ack = 1'b1;
    run_ticks(1);
    bus.i_irq_ack = 1'b0;
    chk("t4 ack key_irq", {7'd0, bus.o_key_irq}, 8'h00);
    chk("t4 held key_down", {7'd0, bus.o_key_down}, 8'h01);
    key_idx = -1;
    run_to('h15);
    chk("t4 pre-release key_down", {7'd0, bus.o_key_down}, 8'h01);
    run_ticks(1);
    chk("t4 release key_down", {7'd0, bus.o_key_down}, 8'h00);
    chk("t4 release key_irq", {7'd0, bus.o_key_irq}, 8'h00);

    // Bounce: one scan only
    key_idx = 'h15;
    run_to('h15);
    run_ticks(1);
    key_idx = -1;
    run_to('h15);
    run_ticks(1);
    chk("t2 key_irq", {7'd0, bus.o_key_irq}, 8'h00);
    chk("t2 kbcode", bus.o_kbcode, 8'h15);
    chk("t2 key_down", {7'd0, bus.o_key_down}, 8'h00);

    // No debounce with shift+ctrl
    bus.i_debounce_en = 1'b0;
    shift_on = 1;
    ctrl_on = 1;
    run_to(0);
    chk("t3 shift_down", {7'd0, bus.o_shift_down}, 8'h01);
    key_idx = 'h0C;
    run_to('h0C);
    chk("t3 pre key_irq", {7'd0, bus.o_key_irq}, 8'h00);
    run_ticks(1);
    chk("t3 kbcode", bus.o_kbcode, 8'hCC);
    chk("t3 key_irq", {7'd0, bus.o_key_irq}, 8'h01);
    chk("t3 key_down", {7'd0, bus.o_key_down}, 8'h01);

    // kb_enable low: ticks ignored, index/FSM/shift cleared, kbcode and irq hold
    bus.i_kb_enable = 1'b0;
    bus.i_scan_tick = 1'b1;
    @(posedge o2);
    #1;
    bus.i_scan_tick = 1'b0;
    idx = 0;
    chk("dis key_scan_L", {2'b00, bus.o_key_scan_L}, 8'h3F);
    chk("dis key_down", {7'd0, bus.o_key_down}, 8'h00);
    chk("dis shift_down", {7'd0, bus.o_shift_down}, 8'h00);
    chk("dis kbcode", bus.o_kbcode, 8'hCC);
    chk("dis key_irq", {7'd0, bus.o_key_irq}, 8'h01);
    bus.i_irq_ack = 1'b1;
    @(posedge o2);
    #1;
    bus.i_irq_ack = 1'b0;
    chk("dis ack key_irq", {7'd0, bus.o_key_irq}, 8'h00);
    bus.i_kb_enable = 1'b1;
    // Shift was cleared and not resampled yet; ctrl held
    run_to('h0C);
    run_ticks(1);
    chk("relatch kbcode", bus.o_kbcode, 8'h8C);
    chk("relatch kb_overrun", {7'd0, bus.o_kb_overrun}, 8'h00);
    bus.i_irq_ack = 1'b1;
    run_ticks(1);
    bus.i_irq_ack = 1'b0;
    shift_on = 0;
    ctrl_on = 0;
    key_idx = -1;
    run_to('h0C);
    run_ticks(1);
    chk("t3 release key_down", {7'd0, bus.o_key_down}, 8'h00);

    // Break held three scans -> single pulse
    brk_pulses = 0;
    brk_on = 1;
    run_ticks(192);
    chk("t5 break pulses", brk_pulses[7:0], 8'h01);
    chk("t5 key_irq", {7'd0, bus.o_key_irq}, 8'h00);
    brk_on = 0;
    run_ticks(64);
    chk("t5 no pulse on release", brk_pulses[7:0], 8'h01);
    brk_on = 1;
    run_to('h30);
    run_ticks(1);
    chk("t5 break_irq rise", {7'd0, bus.o_break_irq}, 8'h01);
    run_ticks(1);
    chk("t5 break_irq fall", {7'd0, bus.o_break_irq}, 8'h00);
    brk_on = 0;
    run_ticks(64);

    // Two debounced keys without an ack in between
    bus.i_debounce_en = 1'b1;
    key_idx = 5;
    run_to(5);
    run_ticks(1);
    run_to(5);
    run_ticks(1);
    chk("t6 first kbcode", bus.o_kbcode, 8'h05);
    chk("t6 first kb_overrun", {7'd0, bus.o_kb_overrun}, 8'h00);
    key_idx = -1;
    run_to(5);
    run_ticks(1);
    key_idx = 7;
    run_to(7);
    run_ticks(1);
    run_to(7);
    run_ticks(1);
    chk("t6 second kbcode", bus.o_kbcode, 8'h07);
    chk("t6 key_irq", {7'd0, bus.o_key_irq}, 8'h01);
    chk("t6 kb_overrun", {7'd0, bus.o_kb_overrun}, {7'd0, OVR_EXP});
    bus.i_ovr_clr = 1'b1;
    run_ticks(1);
    bus.i_ovr_clr = 1'b0;
    chk("t6 ovr_clr", {7'd0, bus.o_kb_overrun}, 8'h00);

    // Reset in the middle of a scan while a key is held
    run_ticks(10);
    rst = 1'b1;
    #2;
    chk("mrst key_scan_L", {2'b00, bus.o_key_scan_L}, 8'h3F);
    chk("mrst kbcode", bus.o_kbcode, 8'h00);
    chk("mrst key_irq", {7'd0, bus.o_key_irq}, 8'h00);
    chk("mrst key_down", {7'd0, bus.o_key_down}, 8'h00);
    chk("mrst kb_overrun", {7'd0, bus.o_kb_overrun}, 8'h00);
    chk("mrst break_irq", {7'd0, bus.o_break_irq}, 8'h00);
    @(negedge o2);
    rst = 1'b0;
    key_idx = -1;
    idx = 0;
    run_ticks(3);
    chk("mrst key_down after", {7'd0, bus.o_key_down}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
